// File: rtl/mcs4_cycle_sequencer.sv
// MCS-4 cycle sequencer: generates the phi1/phi2 clock enables for the
// i4004 bus. It tracks the eight-subcycle instruction cycle, locks it to
// the CPU's sync, and gives the host run/halt/single-step control at
// instruction-cycle boundaries.
module mcs4_cycle_sequencer #(
  parameter int PHASE_TICKS = 4,   // clk cycles per subcycle, even and >= 2
  parameter int CNT_W       = 16   // width of cycle_count
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             run_en,
  input  logic             step,
  input  logic             err_clr,
  output logic             clken_1,
  output logic             clken_2,
  output logic [2:0]       subcycle,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             sync_err
);

  localparam int TICK_W = $clog2(PHASE_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(PHASE_TICKS / 2);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TICK_W-1:0]  r_tick;
  logic [2:0]         r_subcycle;
  logic               r_sync_seen;
  logic               r_step_done;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               r_sync_err;

  logic w_running;
  logic w_wrap;
  logic w_sync_now;
  logic w_resync;
  logic w_complete;
  logic w_start;

  // When PHASE_TICKS is 2, the sync sample edge is also the wrap edge.
  // In that case the live sync value is used in place of the register.
  assign w_running  = (r_state != ST_HALT);
  assign w_wrap     = w_running && (r_tick == TICK_LAST);
  assign w_sync_now = (r_tick == TICK_MID) ? sync : r_sync_seen;
  assign w_resync   = w_wrap && w_sync_now && (r_subcycle != 3'd7);
  assign w_complete = w_wrap && (r_subcycle == 3'd7);

  // State register
  // NOTE: sequential state uses non-blocking (<=), so every register samples
  // pre-edge values and the order of statements inside the block is irrelevant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_HALT;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: leave HALT on run/step; return only on a good completion
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (run_en) begin
          w_state_nxt = ST_RUN;
          w_start     = 1'b1;
        end else if (step) begin
          w_state_nxt = ST_STEP;
          w_start     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_complete && !run_en) w_state_nxt = ST_HALT;
      end
      ST_STEP: begin
        if (w_complete) w_state_nxt = run_en ? ST_RUN : ST_HALT;
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // Datapath: tick/subcycle timing, sync capture, counters and the error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick        <= '0;
      r_subcycle    <= 3'd0;
      r_sync_seen   <= 1'b0;
      r_step_done   <= 1'b0;
      r_cycle_count <= '0;
      r_sync_err    <= 1'b0;
    end else begin
      if (w_start)        r_tick <= '0;
      else if (w_running) r_tick <= w_wrap ? '0 : r_tick + 1'b1;

      if (w_wrap)                               r_sync_seen <= 1'b0;
      else if (w_running && r_tick == TICK_MID) r_sync_seen <= sync;

      if (w_wrap) r_subcycle <= w_sync_now ? 3'd0 : r_subcycle + 3'd1;

      if (w_complete) r_cycle_count <= r_cycle_count + 1'b1;

      r_step_done <= (r_state == ST_STEP) && w_complete;

      // A new misalignment takes priority over a simultaneous clear.
      if (w_resync)     r_sync_err <= 1'b1;
      else if (err_clr) r_sync_err <= 1'b0;
    end
  end

  // The enables are decoded from registers only, so asserting rst drops
  // them at once, without waiting for a clock edge.
  assign clken_1     = w_running && (r_tick == '0);
  assign clken_2     = w_running && (r_tick == TICK_MID);
  assign subcycle    = r_subcycle;
  assign halted      = (r_state == ST_HALT);
  assign step_done   = r_step_done;
  assign cycle_count = r_cycle_count;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_mcs4_cycle_sequencer.sv
// Bench for mcs4_cycle_sequencer. The reference model tracks the position
// within the instruction cycle as one integer (subcycle*PT + tick) plus a
// mode. A bench process emulates the i4004 sync from the model's position.
module tb_mcs4_cycle_sequencer;
  localparam int PT = 4;
  localparam int CW = 16;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic sync = 1'b0, run_en = 1'b0, step = 1'b0, err_clr = 1'b0;
  logic clken_1, clken_2, halted, step_done, sync_err;
  logic [2:0] subcycle;
  logic [CW-1:0] cycle_count;

  int n_vec = 0, n_bad = 0;

  // Reference model state
  int m_mode = M_HALT;
  int m_p = 0;
  bit m_seen = 1'b0, m_err = 1'b0, m_sd = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  bit inject = 1'b0;          // extra sync during subcycle 4
  int n_c1 = 0, n_c2 = 0, n_sd = 0;

  mcs4_cycle_sequencer #(.PHASE_TICKS(PT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sync(sync), .run_en(run_en), .step(step),
    .err_clr(err_clr), .clken_1(clken_1), .clken_2(clken_2),
    .subcycle(subcycle), .halted(halted), .step_done(step_done),
    .cycle_count(cycle_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_HALT; m_p = 0; m_seen = 1'b0; m_err = 1'b0; m_sd = 1'b0; m_cnt = '0;
  endtask

  // Drive sync, advance model by one edge, and count observed pulses
  task automatic clk1();
    int np, nmode;
    bit nseen, nerr, nsd, set_err, seen_now;
    logic [CW-1:0] ncnt;
    sync = (m_mode != M_HALT) && ((m_p / PT == 7) || (inject && m_p / PT == 4));
    np = m_p; nmode = m_mode; nseen = m_seen; nsd = 1'b0; ncnt = m_cnt;
    set_err = 1'b0; seen_now = m_seen;
    if (m_mode == M_HALT) begin
      if (run_en) begin nmode = M_RUN; np = (m_p / PT) * PT; end
      else if (step) begin nmode = M_STEP; np = (m_p / PT) * PT; end
    end else begin
      if (m_p % PT == PT / 2) begin seen_now = sync; nseen = sync; end
      np = (m_p + 1) % (8 * PT);
      if (m_p % PT == PT - 1) begin
        nseen = 1'b0;
        if (seen_now && m_p / PT != 7) begin
          set_err = 1'b1;
          np = 0;
        end else if (m_p / PT == 7) begin
          ncnt = m_cnt + 1'b1;
          if (m_mode == M_STEP) nsd = 1'b1;
          nmode = run_en ? M_RUN : M_HALT;
        end
      end
    end
    nerr = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
    @(posedge clk);
    #1;
    m_p = np; m_mode = nmode; m_seen = nseen; m_err = nerr; m_sd = nsd; m_cnt = ncnt;
    if (clken_1 === 1'b1) n_c1++;
    if (clken_2 === 1'b1) n_c2++;
    if (step_done === 1'b1) n_sd++;
  endtask

  task automatic run_until_p(input int target, input int budget);
    int k = 0;
    while (m_p != target && k < budget) begin clk1(); k++; end
    if (m_p != target) begin
      n_vec++; n_bad++;
      $display("FAIL timeout waiting for position %0d", target);
    end
  endtask

  task automatic run_until_halt(input int budget);
    int k = 0;
    while (m_mode != M_HALT && k < budget) begin clk1(); k++; end
    if (m_mode != M_HALT) begin
      n_vec++; n_bad++;
      $display("FAIL timeout waiting for halt");
    end
  endtask

  task automatic run_until_err(input int budget);
    int k = 0;
    while (!m_err && k < budget) begin clk1(); k++; end
    if (!m_err) begin
      n_vec++; n_bad++;
      $display("FAIL timeout waiting for sync error");
    end
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    check("clken_1", clken_1, (m_mode != M_HALT) && (m_p % PT == 0));
    check("clken_2", clken_2, (m_mode != M_HALT) && (m_p % PT == PT / 2));
    check("subcycle", subcycle, m_p / PT);
    check("halted", halted, m_mode == M_HALT);
    check("step_done", step_done, m_sd);
    check("cycle_count", cycle_count, m_cnt);
    check("sync_err", sync_err, m_err);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // 1: reset values, then a long halt
    #2;
    check("rst_halted", halted, 1);
    check("rst_clken_1", clken_1, 0);
    check("rst_count", cycle_count, 0);
    check("rst_subcycle", subcycle, 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    n_c1 = 0; n_c2 = 0;
    repeat (20) clk1();
    check("halt_no_c1", n_c1, 0);
    check("halt_no_c2", n_c2, 0);
    check("halt_halted", halted, 1);

    // 2: free run, sync during every subcycle 7
    run_en = 1'b1;
    clk1();
    check("run_lat_c1", clken_1, 1);
    for (int i = 1; i <= 96; i++) begin
      clk1();
      if (i == 1) check("run_c1_low", clken_1, 0);
      if (i == 2) check("run_c2_clk3", clken_2, 1);
      if (i == 4) check("run_c1_period", clken_1, 1);
      if (i == 8) check("run_subcycle2", subcycle, 2);
    end
    check("run_count3", cycle_count, 3);
    check("run_no_err", sync_err, 0);

    // 3: drop run_en at subcycle 3; phi1 at subcycles 4..7, phi2 at 3..7
    run_until_p(3 * PT, 64);
    run_en = 1'b0;
    n_c1 = 0; n_c2 = 0;
    run_until_halt(64);
    check("drop_c1", n_c1, 4);
    check("drop_c2", n_c2, 5);
    check("drop_halted", halted, 1);
    check("drop_subcycle", subcycle, 0);
    check("drop_count", cycle_count, 4);

    // 4: single step, with a second step pulse mid-step that is ignored
    n_c1 = 0; n_c2 = 0; n_sd = 0;
    step = 1'b1; clk1(); step = 1'b0;
    repeat (20) clk1();
    step = 1'b1; clk1(); step = 1'b0;
    repeat (40) clk1();
    check("step_c1", n_c1, 8);
    check("step_c2", n_c2, 8);
    check("step_done_n", n_sd, 1);
    check("step_halted", halted, 1);
    check("step_count", cycle_count, 5);

    // 5: sync misaligned at subcycle 4, clear, then a clear that collides
    run_en = 1'b1;
    clk1();
    inject = 1'b1;
    run_until_err(64);
    inject = 1'b0;
    check("err_set", sync_err, 1);
    check("err_resync", subcycle, 0);
    check("err_count", cycle_count, 5);
    err_clr = 1'b1; clk1(); err_clr = 1'b0;
    check("err_cleared", sync_err, 0);
    inject = 1'b1;
    run_until_p(4 * PT + PT - 1, 64);
    err_clr = 1'b1; clk1(); err_clr = 1'b0;
    inject = 1'b0;
    check("err_set_wins", sync_err, 1);

    // 6: step and run_en together from halt, then reset mid-cycle
    run_en = 1'b0;
    run_until_halt(80);
    n_sd = 0;
    run_en = 1'b1; step = 1'b1; clk1(); step = 1'b0;
    check("both_run", halted, 0);
    repeat (40) clk1();
    check("both_no_sd", n_sd, 0);
    run_until_p(5 * PT, 64);
    check("pre_rst_c1", clken_1, 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_c1", clken_1, 0);
    check("rst_async_c2", clken_2, 0);
    check("rst_async_cnt", cycle_count, 0);
    check("rst_async_sc", subcycle, 0);
    run_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) clk1();
    check("post_rst_halted", halted, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
